// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned INST_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PC_HOLD  = 3'd0,
    PC_INC   = 3'd1,
    PC_ABS   = 3'd2,
    PC_REL   = 3'd3,
    PC_START = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, increment, absolute/relative branch, start.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned A = ADDR_W_DEF
) (
  input  pc_sel_e        sel_i,
  input  logic [A-1:0]   pc_i,
  input  logic [A-1:0]   inst_pc_i,
  input  logic [A-1:0]   target_i,
  input  logic [A-1:0]   start_addr_i,
  output logic [A-1:0]   next_pc_c_o
);

  // Arithmetic is A bits wide, so increment and relative targets wrap modulo 2**A.
  always_comb begin
    next_pc_c_o = pc_i;
    unique case (sel_i)
      PC_HOLD:  next_pc_c_o = pc_i;
      PC_INC:   next_pc_c_o = pc_i + A'(1);
      PC_ABS:   next_pc_c_o = target_i;
      PC_REL:   next_pc_c_o = inst_pc_i + target_i;
      PC_START: next_pc_c_o = start_addr_i;
      default:  next_pc_c_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the ROM address, registers the fetched
// instruction towards decode with a valid/ready handshake, handles branch and halt.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned A = ADDR_W_DEF,
  parameter int unsigned W = INST_W_DEF
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [A-1:0] StartAddr,
  output logic [A-1:0] InstAddress,
  input  logic [W-1:0] InstIn,
  output logic [W-1:0] Inst,
  output logic [A-1:0] InstPC,
  output logic         InstValid,
  input  logic         InstReady,
  input  logic         BranchEn,
  input  logic         BranchRel,
  input  logic [A-1:0] BranchTarget,
  input  logic         Halt,
  output logic         Busy,
  output logic         Done
);

  state_e       state_q, state_d;
  logic [A-1:0] pc_q, pc_d;
  logic [W-1:0] inst_q, inst_d;
  logic [A-1:0] inst_pc_q, inst_pc_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  pc_sel_e      pc_sel;
  logic         accept;

  assign accept = valid_q && InstReady;

  pc_next #(.A(A)) u_pc_next (
    .sel_i        (pc_sel),
    .pc_i         (pc_q),
    .inst_pc_i    (inst_pc_q),
    .target_i     (BranchTarget),
    .start_addr_i (StartAddr),
    .next_pc_c_o  (pc_d)
  );

  // Next-state and output decode; Halt outranks BranchEn, which outranks a plain fetch.
  always_comb begin
    state_d   = state_q;
    pc_sel    = PC_HOLD;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    unique case (state_q)
      IDLE, HALTED: begin
        valid_d = 1'b0;
        if (Start) begin
          state_d = RUN;
          pc_sel  = PC_START;
        end
      end
      RUN: begin
        if (accept && Halt) begin
          state_d = HALTED;
          valid_d = 1'b0;
        end else if (accept && BranchEn) begin
          pc_sel  = BranchRel ? PC_REL : PC_ABS;
          valid_d = 1'b0;
        end else if (!valid_q || accept) begin
          pc_sel    = PC_INC;
          inst_d    = InstIn;
          inst_pc_d = pc_q;
          valid_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == HALTED);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstPC      = inst_pc_q;
  assign InstValid   = valid_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: start, stream, stall, branches, halt, wrap, reset.
module tb_fetch_ctrl;

  localparam int unsigned A = 10;
  localparam int unsigned W = 9;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [A-1:0] start_addr;
  logic [A-1:0] inst_address;
  logic [W-1:0] inst_in;
  logic [W-1:0] inst;
  logic [A-1:0] inst_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic         branch_en;
  logic         branch_rel;
  logic [A-1:0] branch_target;
  logic         halt;
  logic         busy;
  logic         done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction ROM contents: a simple address hash so each word is distinct.
  function automatic logic [W-1:0] rom(input logic [A-1:0] a);
    return W'(32'(a) * 7 + 3);
  endfunction

  assign inst_in = rom(inst_address);

  fetch_ctrl #(.A(A), .W(W)) dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .Start        (start),
    .StartAddr    (start_addr),
    .InstAddress  (inst_address),
    .InstIn       (inst_in),
    .Inst         (inst),
    .InstPC       (inst_pc),
    .InstValid    (inst_valid),
    .InstReady    (inst_ready),
    .BranchEn     (branch_en),
    .BranchRel    (branch_rel),
    .BranchTarget (branch_target),
    .Halt         (halt),
    .Busy         (busy),
    .Done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot; Inst is only compared while valid.
  task automatic expect_out(input string tag, input int addr, input logic valid,
                            input int pc, input logic bsy, input logic dn);
    check({tag, ".addr"},  32'(inst_address), 32'(addr));
    check({tag, ".valid"}, 32'(inst_valid),   32'(valid));
    check({tag, ".busy"},  32'(busy),         32'(bsy));
    check({tag, ".done"},  32'(done),         32'(dn));
    if (valid) begin
      check({tag, ".pc"},   32'(inst_pc), 32'(pc));
      check({tag, ".inst"}, 32'(inst),    32'(rom(A'(pc))));
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; inst_ready = 1'b0;
    branch_en = 1'b0; branch_rel = 1'b0; branch_target = '0; halt = 1'b0;

    // Reset state
    step(); step();
    expect_out("reset", 0, 1'b0, 0, 1'b0, 1'b0);
    check("reset.inst", 32'(inst), 32'h0);
    check("reset.instpc", 32'(inst_pc), 32'h0);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    step(); step();
    expect_out("idle_hold", 0, 1'b0, 0, 1'b0, 1'b0);

    // Start at 5, free-running stream
    start = 1'b1; start_addr = A'(5);
    step(); start = 1'b0;
    expect_out("start", 5, 1'b0, 0, 1'b1, 1'b0);
    step(); expect_out("s5", 6, 1'b1, 5, 1'b1, 1'b0);
    step(); expect_out("s6", 7, 1'b1, 6, 1'b1, 1'b0);
    step(); expect_out("s7", 8, 1'b1, 7, 1'b1, 1'b0);
    step(); expect_out("s8", 9, 1'b1, 8, 1'b1, 1'b0);

    // Three-cycle stall on InstPC=8
    inst_ready = 1'b0;
    branch_en = 1'b1; branch_target = A'(10'h200);
    for (int i = 0; i < 3; i++) begin
      step(); expect_out("stall", 9, 1'b1, 8, 1'b1, 1'b0);
    end
    branch_en = 1'b0;
    inst_ready = 1'b1;
    // Start during RUN must be ignored
    start = 1'b1; start_addr = A'(10'h300);
    step(); expect_out("resume9", 10, 1'b1, 9, 1'b1, 1'b0);
    step(); expect_out("start_ignored", 11, 1'b1, 10, 1'b1, 1'b0);
    start = 1'b0;

    // Relative branch from 10 by -3
    branch_en = 1'b1; branch_rel = 1'b1; branch_target = A'(10'h3FD);
    step(); branch_en = 1'b0;
    expect_out("rel_bubble", 7, 1'b0, 0, 1'b1, 1'b0);
    step(); expect_out("rel_tgt", 8, 1'b1, 7, 1'b1, 1'b0);

    // Absolute branch from 7 to 0x020
    branch_en = 1'b1; branch_rel = 1'b0; branch_target = A'(10'h020);
    step(); branch_en = 1'b0;
    expect_out("abs_bubble", 10'h020, 1'b0, 0, 1'b1, 1'b0);
    step(); expect_out("abs_tgt", 10'h021, 1'b1, 10'h020, 1'b1, 1'b0);

    // Halt beats branch; PC frozen at 0x021
    halt = 1'b1; branch_en = 1'b1; branch_target = A'(10'h100);
    step(); halt = 1'b0; branch_en = 1'b0;
    expect_out("halt", 10'h021, 1'b0, 0, 1'b0, 1'b1);
    inst_ready = 1'b0; halt = 1'b1;
    step(); inst_ready = 1'b1; halt = 1'b0;
    step(); expect_out("halted_hold", 10'h021, 1'b0, 0, 1'b0, 1'b1);

    // Restart from HALTED at 3
    start = 1'b1; start_addr = A'(3);
    step(); start = 1'b0;
    expect_out("restart", 3, 1'b0, 0, 1'b1, 1'b0);
    step(); expect_out("restart3", 4, 1'b1, 3, 1'b1, 1'b0);

    // Halt again, then wrap test from 1022
    halt = 1'b1;
    step(); halt = 1'b0;
    expect_out("halt2", 4, 1'b0, 0, 1'b0, 1'b1);
    start = 1'b1; start_addr = A'(1022);
    step(); start = 1'b0;
    expect_out("wrap_start", 1022, 1'b0, 0, 1'b1, 1'b0);
    step(); expect_out("w1022", 1023, 1'b1, 1022, 1'b1, 1'b0);
    step(); expect_out("w1023", 0, 1'b1, 1023, 1'b1, 1'b0);
    step(); expect_out("w0", 1, 1'b1, 0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a stall
    inst_ready = 1'b0;
    step(); expect_out("pre_rst_stall", 1, 1'b1, 0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 1'b0, 0, 1'b0, 1'b0);
    check("async_rst.inst", 32'(inst), 32'h0);
    check("async_rst.instpc", 32'(inst_pc), 32'h0);
    inst_ready = 1'b1;
    step(); rst_n = 1'b1;
    step(); step();
    expect_out("post_rst_idle", 0, 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001: Parameter A, default 10, instruction-ROM address width.
REQ-002: Parameter W, default 9, instruction width.
REQ-003: Clk  input  1  sole clock; all state updates on rising edge.
REQ-004: Reset_n  input  1  asynchronous, active-low reset.
REQ-005: Start  input  1  begin execution at StartAddr; honoured only in IDLE or HALTED.
REQ-006: StartAddr  input  A  first fetch address.
REQ-007: InstAddress  output  A  program counter, driven to the combinational instruction ROM.
REQ-008: InstIn  input  W  ROM data for InstAddress, same cycle.
REQ-009: Inst  output  W  registered instruction presented to decode.
REQ-010: InstPC  output  A  address Inst was fetched from.
REQ-011: InstValid  output  1  Inst/InstPC valid.
REQ-012: InstReady  input  1  decode accepts Inst; a handshake occurs on a cycle with InstValid&&InstReady ("accept").
REQ-013: BranchEn  input  1  accepted instruction redirects fetch; sampled only on accept.
REQ-014: BranchRel  input  1  1 = PC-relative target, 0 = absolute target.
REQ-015: BranchTarget  input  A  absolute address, or two's-complement offset when BranchRel=1.
REQ-016: Halt  input  1  accepted instruction stops execution; sampled only on accept.
REQ-017: Busy  output  1  high in RUN.
REQ-018: Done  output  1  high in HALTED.

Function
REQ-019: FSM states are IDLE, RUN and HALTED.
REQ-020: IDLE/HALTED + Start transitions to RUN with PC<=StartAddr, InstValid<=0, Done<=0.
REQ-021: Start is ignored in RUN.
REQ-022: In RUN, a fetch occurs on any edge where !InstValid or accept: Inst<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1.
REQ-023: Latency is 1 cycle from InstAddress to Inst; first InstValid is 2 edges after the Start edge.
REQ-024: Stall (InstValid && !InstReady) holds PC, Inst, InstPC and InstValid unchanged.
REQ-025: PC increment is modulo 2**A; 2**A-1 wraps to 0 with no flag.
REQ-026: Accept with BranchEn=1, Halt=0: PC<=target, InstValid<=0 (wrong-path fetch discarded), state stays RUN; penalty is exactly 1 bubble.
REQ-027: Branch target = BranchTarget when BranchRel=0, else (InstPC + BranchTarget) modulo 2**A.
REQ-028: Accept with Halt=1 transitions to HALTED with InstValid<=0 and PC frozen; Halt has priority over BranchEn.
REQ-029: In IDLE/HALTED, InstValid=0 and all inputs other than Start/StartAddr are ignored.
REQ-030: Busy and Done are decoded from state only (registered, glitch-free).

Reset
REQ-031: Reset_n low asynchronously forces state=IDLE, PC=0, Inst=0, InstPC=0, InstValid=0, Busy=0, Done=0.
REQ-032: Reset asserted mid-RUN discards any in-flight instruction; no accept completes after assertion.
REQ-033: After release, the block stays in IDLE until Start.

Structure
REQ-034: Shared package fetch_pkg holds the state enum (IDLE, RUN, HALTED) and the defaults for A and W.
REQ-035: Sub-module pc_next (combinational) computes the next PC (hold/increment/absolute/relative/start) and is instantiated once.
REQ-036: The instruction ROM is outside this block; fetch_ctrl drives only InstAddress and reads InstIn.

Verification
REQ-037: Reset, Start with StartAddr=5, InstReady=1 -> InstAddress 5,6,7 on successive cycles; InstPC 5,6,7 with InstValid=1 starting 2 edges after Start.
REQ-038: InstReady=0 for 3 cycles while InstPC=8 -> InstAddress=9, Inst, InstPC=8 and InstValid=1 held stable; resumes with InstPC=9 after InstReady=1.
REQ-039: Accept InstPC=7 with BranchEn=1, BranchRel=0, BranchTarget=0x020 -> next cycle InstValid=0, InstAddress=0x020; following cycle InstPC=0x020, InstValid=1.
REQ-040: Accept InstPC=10 with BranchRel=1, BranchTarget=-3 -> fetch resumes at 7; StartAddr=1022 -> InstPC sequence 1022,1023,0.
REQ-041: Accept with Halt=1 and BranchEn=1 -> Done=1, Busy=0, InstValid=0, PC frozen; a Start during RUN is ignored; Start with StartAddr=3 in HALTED -> RUN, first InstPC=3.
REQ-042: Reset_n pulsed low mid-stall -> all outputs 0 immediately without waiting for a Clk edge; state IDLE.
